// File: rtl/de2i_150_qsys_oci_trace_pkg.sv
// rtl/de2i_150_qsys_oci_trace_pkg.sv - shared types and widths for the OCI DCT trace capture (option: DE2I_150_QSYS_OCI_TRACE_TIMESTAMP_EN)
package de2i_150_qsys_oci_trace_pkg;

   // Capture sequencing: collect entries, then flush, then hold until reset
   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } trace_state_e;

   // Width of the optional free-running cycle stamp
   localparam int TS_W = 32;

   // Width of one queued entry: {count, buffer[, stamp]}
   function automatic int entry_w(input int count_w, input int dct_w);
`ifdef DE2I_150_QSYS_OCI_TRACE_TIMESTAMP_EN
      return count_w + dct_w + TS_W;
`else
      return count_w + dct_w;
`endif
   endfunction

endpackage

// File: rtl/de2i_150_qsys_nios2_oci_trace_capture_if.sv
// rtl/de2i_150_qsys_nios2_oci_trace_capture_if.sv - valid/ready output stream of the trace capture
interface de2i_150_qsys_nios2_oci_trace_capture_if #(
   parameter int ENTRY_W = 34
) ();
   logic               out_valid;
   logic               out_ready;
   logic [ENTRY_W-1:0] out_data;

   // Producer side (the capture block)
   modport master (output out_valid, output out_data, input out_ready);
   // Consumer side
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/de2i_150_qsys_oci_trace_fifo.sv
// rtl/de2i_150_qsys_oci_trace_fifo.sv - synchronous FIFO with registered occupancy and valid
module de2i_150_qsys_oci_trace_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 34,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;
   logic             valid_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign do_pop  = pop_i && valid_q;
   // When full, a push is still taken if the head leaves in the same edge
   assign do_push = push_i && (!full_o || do_pop);

   // Next occupancy from the accepted push/pop pair
   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointers, occupancy and the registered valid flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         valid_q <= (level_d != '0);
      end
   end

   // Entry storage; contents are only observed while valid, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Head is masked to zero when empty so a reset FIFO presents all-zero data
   assign data_o  = valid_q ? mem_q[rd_ptr_q] : '0;
   assign valid_o = valid_q;
   assign level_o = level_q;

endmodule

// File: rtl/de2i_150_qsys_nios2_oci_trace_capture.sv
// rtl/de2i_150_qsys_nios2_oci_trace_capture.sv - DCT trace capture top: event detect, FSM, counters (option: DE2I_150_QSYS_OCI_TRACE_TIMESTAMP_EN)
module de2i_150_qsys_nios2_oci_trace_capture
   import de2i_150_qsys_oci_trace_pkg::*;
#(
   parameter  int DCT_W   = 30,
   parameter  int COUNT_W = 4,
   parameter  int DEPTH   = 16,
   parameter  int DROP_W  = 16,
   localparam int ENTRY_W = entry_w(COUNT_W, DCT_W),
   localparam int LVL_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DCT_W-1:0]   dct_buffer,
   input  logic [COUNT_W-1:0] dct_count,
   input  logic               test_ending,
   input  logic               test_has_ended,
   de2i_150_qsys_nios2_oci_trace_capture_if.master out_if,
   output logic [LVL_W-1:0]   level,
   output logic               overflow,
   output logic [DROP_W-1:0]  drop_count,
   output logic [DROP_W-1:0]  frame_count,
   output logic               done
);

   trace_state_e       state_q;
   trace_state_e       state_d;
   logic [COUNT_W-1:0] prev_count_q;
   logic               overflow_q;
   logic [DROP_W-1:0]  drop_q;
   logic [DROP_W-1:0]  frame_q;
   logic               done_q;

   logic               count_changed;
   logic               new_ev;
   logic               frame_ev;
   logic               push_req;
   logic               pop;
   logic               drop;
   logic [ENTRY_W-1:0] entry;
   logic [ENTRY_W-1:0] fifo_data;
   logic               fifo_valid;
   logic               fifo_full;
   logic               fifo_empty;
   logic [LVL_W-1:0]   fifo_level;

   // A change of dct_count is either a new entry (nonzero) or a frame wrap (zero)
   assign count_changed = (dct_count != prev_count_q);
   assign new_ev        = count_changed && (dct_count != '0);
   assign frame_ev      = count_changed && (dct_count == '0);
   assign push_req      = (state_q == CAPTURE) && new_ev;
   assign pop           = fifo_valid && out_if.out_ready;
   assign drop          = push_req && fifo_full && !pop;

`ifdef DE2I_150_QSYS_OCI_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   // Free-running cycle stamp; the value before the push edge tags the entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_q + 1'b1;
   end

   assign entry = {dct_count, dct_buffer, ts_q};
`else
   assign entry = {dct_count, dct_buffer};
`endif

   // Sequencing: the push in the cycle that ends capture is still accepted
   always_comb begin
      state_d = state_q;
      case (state_q)
         CAPTURE: if (test_ending || test_has_ended) state_d = DRAIN;
         DRAIN:   if (fifo_empty && test_has_ended)  state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = CAPTURE;
      endcase
   end

   // FSM state, previous count, overflow/drop/frame counters and done flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CAPTURE;
         prev_count_q <= '0;
         overflow_q   <= 1'b0;
         drop_q       <= '0;
         frame_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_count_q <= dct_count;
         done_q       <= (state_d == DONE);
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + 1'b1;
         end
         if (frame_ev && (state_q != DONE)) frame_q <= frame_q + 1'b1;
      end
   end

   de2i_150_qsys_oci_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push_req),
      .data_i  (entry),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .valid_o (fifo_valid),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign out_if.out_valid = fifo_valid;
   assign out_if.out_data  = fifo_data;
   assign level            = fifo_level;
   assign overflow         = overflow_q;
   assign drop_count       = drop_q;
   assign frame_count      = frame_q;
   assign done             = done_q;

endmodule
